// File: rtl/cache_memory_hierarchy.sv
// cache_memory_hierarchy
//   Read-only two-level memory: a direct-mapped cache in front of a slow main
//   memory. The caller holds MemRead high until DataReady, then drops it.
//   Main-memory word a holds a zero-extended to DATA_W bits.
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset (invalidates every line)
//   address    word address, sampled when a request is accepted in IDLE
//   MemRead    level-sensitive read request
//   data       read word, valid while DataReady=1
//   DataReady  request complete (registered)
//   HMbar      1 = hit, 0 = miss, valid while DataReady=1
module cache_memory_hierarchy #(
  parameter int    ADDR_W        = 15,
  parameter int    DATA_W        = 32,
  parameter int    BLOCK_WORDS   = 4,
  parameter int    CACHE_WORDS   = 8192,
  parameter int    MEM_LATENCY   = 4,
  parameter string MEM_INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic              MemRead,
  output logic [DATA_W-1:0] data,
  output logic              DataReady,
  output logic              HMbar
);

  localparam int OFF_W  = $clog2(BLOCK_WORDS);
  localparam int LINES  = CACHE_WORDS / BLOCK_WORDS;
  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int LINE_W = BLOCK_WORDS * DATA_W;
  localparam int CNT_W  = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

  // File-loaded contents are not modelled in this synthesizable view; the
  // address-valued pattern is only produced when no file is named.
  localparam bit ADDR_PATTERN = (MEM_INIT_FILE == "");

  typedef enum logic [2:0] {IDLE, COMPARE, FETCH, FILL, DONE} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] req_addr;
  logic [CNT_W-1:0]  cnt;

  logic [LINE_W-1:0] line_mem [LINES];
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [LINES-1:0]  valid;

  logic [OFF_W-1:0]  req_off;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic              hit;
  logic [DATA_W-1:0] hit_word;
  logic [LINE_W-1:0] fill_line;

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return ADDR_PATTERN ? DATA_W'(a) : '0;
  endfunction

  assign req_off  = req_addr[OFF_W-1:0];
  assign req_idx  = req_addr[OFF_W +: IDX_W];
  assign req_tag  = req_addr[ADDR_W-1 -: TAG_W];
  assign hit      = valid[req_idx] && (tag_mem[req_idx] == req_tag);
  assign hit_word = line_mem[req_idx][req_off*DATA_W +: DATA_W];

  always_comb begin
    fill_line = '0;
    for (int unsigned w = 0; w < BLOCK_WORDS; w++) begin
      fill_line[w*DATA_W +: DATA_W] =
        mem_word({req_addr[ADDR_W-1:OFF_W], OFF_W'(w)});
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (MemRead) state_n = COMPARE;
      COMPARE: state_n = hit ? DONE : FETCH;
      FETCH:   if (cnt == CNT_LAST) state_n = FILL;
      FILL:    state_n = MemRead ? DONE : IDLE;
      DONE:    if (!MemRead) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // DataReady rises one edge after entering DONE, which yields the 2-edge hit
  // latency; a request abandoned before DONE therefore never raises it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_addr  <= '0;
      cnt       <= '0;
      data      <= '0;
      HMbar     <= 1'b0;
      DataReady <= 1'b0;
      valid     <= '0;
    end else begin
      case (state)
        IDLE: begin
          DataReady <= 1'b0;
          if (MemRead) req_addr <= address;
        end
        COMPARE: begin
          cnt <= '0;
          if (hit) begin
            data  <= hit_word;
            HMbar <= 1'b1;
          end
        end
        FETCH: cnt <= cnt + 1'b1;
        FILL: begin
          valid[req_idx] <= 1'b1;
          data           <= mem_word(req_addr);
          HMbar          <= 1'b0;
        end
        DONE:    DataReady <= MemRead;
        default: DataReady <= 1'b0;
      endcase
    end
  end

  // Line storage has no reset; valid bits alone decide whether it is used.
  always_ff @(posedge clk) begin
    if (state == FILL) begin
      line_mem[req_idx] <= fill_line;
      tag_mem[req_idx]  <= req_tag;
    end
  end

endmodule

// File: tb/tb_cache_memory_hierarchy.sv
module tb_cache_memory_hierarchy;

  localparam int LAT      = 4;
  localparam int HIT_LAT  = 2;
  localparam int MISS_LAT = 3 + LAT;

  logic        clk = 1'b0;
  logic        rst;
  logic [14:0] address;
  logic        MemRead;
  logic [31:0] data;
  logic        DataReady;
  logic        HMbar;

  int tests = 0;
  int fails = 0;
  logic last_hm;

  cache_memory_hierarchy #(
    .ADDR_W(15), .DATA_W(32), .BLOCK_WORDS(4), .CACHE_WORDS(8192),
    .MEM_LATENCY(LAT), .MEM_INIT_FILE("")
  ) dut (
    .clk(clk), .rst(rst), .address(address), .MemRead(MemRead),
    .data(data), .DataReady(DataReady), .HMbar(HMbar)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Raise MemRead, count edges after the accepting edge until DataReady.
  task automatic start_read(input logic [14:0] a, output int n);
    @(negedge clk);
    address = a;
    MemRead = 1'b1;
    @(posedge clk);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!DataReady && n < 40);
  endtask

  task automatic end_read(input string tag);
    @(negedge clk);
    MemRead = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_drop"}, 32'(DataReady), 32'd0);
  endtask

  task automatic do_read(input string tag, input logic [14:0] a,
                         input logic exp_hit, input int exp_lat);
    int n;
    start_read(a, n);
    chk({tag, "_lat"},  32'(n), 32'(exp_lat));
    chk({tag, "_data"}, data, 32'(a));
    chk({tag, "_hm"},   32'(HMbar), 32'(exp_hit));
    last_hm = HMbar;
    end_read(tag);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int n;
    int hits;
    int misses;
    int bad_data;
    int ready_seen;
    logic [31:0] held_d;
    logic        held_h;

    rst = 1'b0;
    MemRead = 1'b0;
    address = '0;
    #12;
    chk("rst_ready", 32'(DataReady), 32'd0);
    chk("rst_hm",    32'(HMbar), 32'd0);
    chk("rst_data",  data, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // First access misses, rest of the block hits.
    do_read("t1_1024", 15'd1024, 1'b0, MISS_LAT);
    do_read("t2_1025", 15'd1025, 1'b1, HIT_LAT);
    do_read("t2_1026", 15'd1026, 1'b1, HIT_LAT);
    do_read("t2_1027", 15'd1027, 1'b1, HIT_LAT);

    // Sequential sweep over the full cache capacity from a cold cache.
    pulse_reset();
    hits = 0;
    misses = 0;
    bad_data = 0;
    for (int i = 0; i < 8192; i++) begin
      logic [14:0] a;
      a = 15'(1024 + i);
      start_read(a, n);
      if (data !== 32'(a)) bad_data++;
      if (a[1:0] == 2'b00) chk("t3_lat_miss", 32'(n), 32'(MISS_LAT));
      else                 chk("t3_lat_hit",  32'(n), 32'(HIT_LAT));
      if (HMbar === 1'b1) hits++;
      else                misses++;
      @(negedge clk);
      MemRead = 1'b0;
      @(posedge clk);
    end
    chk("t3_misses", 32'(misses), 32'd2048);
    chk("t3_hits",   32'(hits),   32'd6144);
    chk("t3_data",   32'(bad_data), 32'd0);

    // Tag conflicts on index 0.
    do_read("t4_0",    15'd0,    1'b0, MISS_LAT);
    do_read("t4_8192", 15'd8192, 1'b0, MISS_LAT);
    do_read("t4_0b",   15'd0,    1'b0, MISS_LAT);

    // Reset while the miss is in FETCH.
    do_read("t5_600", 15'd600, 1'b0, MISS_LAT);
    @(negedge clk);
    address = 15'd8792;
    MemRead = 1'b1;
    @(posedge clk);           // accept
    @(posedge clk);           // COMPARE -> FETCH
    @(posedge clk);           // in FETCH
    #2;
    rst = 1'b0;
    MemRead = 1'b0;
    #1;
    chk("t5_ready", 32'(DataReady), 32'd0);
    chk("t5_data",  data, 32'd0);
    chk("t5_hm",    32'(HMbar), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    do_read("t5_8792", 15'd8792, 1'b0, MISS_LAT);
    do_read("t5_600b", 15'd600,  1'b0, MISS_LAT);

    // MemRead abandoned during COMPARE: no response, but the line is filled.
    @(negedge clk);
    address = 15'd3000;
    MemRead = 1'b1;
    @(posedge clk);
    @(negedge clk);
    MemRead = 1'b0;
    address = 15'd77;
    ready_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (DataReady === 1'b1) ready_seen++;
    end
    chk("t7_no_ready", 32'(ready_seen), 32'd0);
    do_read("t7_3000", 15'd3000, 1'b1, HIT_LAT);

    // Held MemRead in DONE: miss response must not turn into a hit.
    start_read(15'd2000, n);
    chk("t6_lat", 32'(n), 32'(MISS_LAT));
    held_d = data;
    held_h = HMbar;
    chk("t6_data", held_d, 32'd2000);
    chk("t6_hm",   32'(held_h), 32'd0);
    ready_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (DataReady === 1'b1 && data === 32'd2000 && HMbar === 1'b0) ready_seen++;
    end
    chk("t6_hold_miss", 32'(ready_seen), 32'd10);
    end_read("t6_miss");

    start_read(15'd2000, n);
    chk("t6_hit_lat", 32'(n), 32'(HIT_LAT));
    ready_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (DataReady === 1'b1 && data === 32'd2000 && HMbar === 1'b1) ready_seen++;
    end
    chk("t6_hold_hit", 32'(ready_seen), 32'd10);
    end_read("t6_hit");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
